// File: rtl/regfile_2r1w_param.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_param
//
// Parametrised operand store: DEPTH x DATA_W registers, one byte-enabled
// write port and two independent combinational read ports. An optional
// bypass lets a read of the entry being written this cycle return the
// merged (post-write) value. An optional hardwired-zero register 0 reads
// as zero and ignores writes. A built-in clear engine zeroes the array one
// entry per clock.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   wr_en/addr/data/be  write request; wr_be[k] covers wr_data[8k+7:8k]
//   rd0_addr/rd0_data   read port 0 (combinational, zero latency)
//   rd1_addr/rd1_data   read port 1 (combinational, zero latency)
//   clr_req             start a bulk clear (pulse or level)
//   clr_busy            high while the clear engine walks the array
//   clr_done            one-cycle pulse after the last entry is zeroed
//   dbg_state           clear FSM state: 0 = IDLE, 1 = CLEAR, 2 = DONE
//
// Clear handshake: clr_req is sampled on every rising edge while the engine
// is in IDLE or DONE; a sampled 1 starts a clear on that edge. clr_busy is
// then high for exactly DEPTH cycles, followed by one cycle of clr_done.
// clr_req is ignored while clr_busy is high, and writes presented while
// clr_busy is high are dropped (no queueing, no bypass).
// ---------------------------------------------------------------------------
module regfile_2r1w_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int NB      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NB-1:0]     wr_be,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic [DATA_W-1:0] be_mask;
    logic [DATA_W-1:0] wr_merged;

    // Addresses can exceed DEPTH-1 when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Write qualification and byte merge. rst_n gates acceptance so the
    // bypass path cannot leak write data onto the read ports during reset.
    always_comb begin
        wr_ok = rst_n && wr_en && (state_q != ST_CLEAR) && addr_ok(wr_addr)
                && !(ZERO_REG && (wr_addr == '0));
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[8*b +: 8] = {8{wr_be[b]}};
        end
        wr_merged = (mem[wr_addr] & ~be_mask) | (wr_data & be_mask);
    end

    // Storage. The clear engine owns the array while in CLEAR, which is
    // also why wr_ok excludes that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // Read port 0
    always_comb begin
        rd0_data = '0;
        if (addr_ok(rd0_addr) && !(ZERO_REG && (rd0_addr == '0))) begin
            if (BYPASS && wr_ok && (rd0_addr == wr_addr)) begin
                rd0_data = wr_merged;
            end else begin
                rd0_data = mem[rd0_addr];
            end
        end
    end

    // Read port 1
    always_comb begin
        rd1_data = '0;
        if (addr_ok(rd1_addr) && !(ZERO_REG && (rd1_addr == '0))) begin
            if (BYPASS && wr_ok && (rd1_addr == wr_addr)) begin
                rd1_data = wr_merged;
            end else begin
                rd1_data = mem[rd1_addr];
            end
        end
    end

    // Clear FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear FSM: next state. DONE behaves like IDLE for clr_req so a held
    // request chains straight into another clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_done  = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w_param
//
// Three 32x16 instances share one stimulus bus: cfg0 = defaults (bypass on),
// cfg1 = bypass off, cfg2 = hardwired zero register. A fourth instance is
// 64-bit wide and 32 deep with its own stimulus. Expected values come from
// spec constants and an array-based reference model of the register file.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_2r1w_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- shared 32x16 stimulus ----------------
    logic        wr_en, clr_req;
    logic [3:0]  wr_addr, rd0_addr, rd1_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [2:0][31:0] r0, r1;
    logic [2:0]       busy, done;
    logic [2:0][1:0]  st;

    // ---------------- 64x32 stimulus ----------------
    logic        w_wr_en, w_clr_req;
    logic [4:0]  w_wr_addr, w_rd0_addr, w_rd1_addr;
    logic [63:0] w_wr_data, w_r0, w_r1;
    logic [7:0]  w_wr_be;
    logic        w_busy, w_done;
    logic [1:0]  w_st;

    regfile_2r1w_param #(.DATA_W(32), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_c0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd0_addr(rd0_addr), .rd0_data(r0[0]), .rd1_addr(rd1_addr),
        .rd1_data(r1[0]), .clr_req(clr_req), .clr_busy(busy[0]), .clr_done(done[0]),
        .dbg_state(st[0]));
    regfile_2r1w_param #(.DATA_W(32), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd0_addr(rd0_addr), .rd0_data(r0[1]), .rd1_addr(rd1_addr),
        .rd1_data(r1[1]), .clr_req(clr_req), .clr_busy(busy[1]), .clr_done(done[1]),
        .dbg_state(st[1]));
    regfile_2r1w_param #(.DATA_W(32), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd0_addr(rd0_addr), .rd0_data(r0[2]), .rd1_addr(rd1_addr),
        .rd1_data(r1[2]), .clr_req(clr_req), .clr_busy(busy[2]), .clr_done(done[2]),
        .dbg_state(st[2]));
    regfile_2r1w_param #(.DATA_W(64), .DEPTH(32)) dut_w (
        .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .wr_be(w_wr_be), .rd0_addr(w_rd0_addr), .rd0_data(w_r0), .rd1_addr(w_rd1_addr),
        .rd1_data(w_r1), .clr_req(w_clr_req), .clr_busy(w_busy), .clr_done(w_done),
        .dbg_state(w_st));

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model (32x16 configs) ----------------
    logic [31:0] mem_m [16];   // cfg0 / cfg1 contents
    logic [31:0] mem_z [16];   // cfg2 contents (entry 0 never written)
    int          m_phase;      // 0 idle, 1 clearing, 2 done
    int          m_cnt;        // next entry the clear will zero

    function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Value the read port of config c must show for address a right now.
    function automatic logic [31:0] exp_rd(input logic [3:0] a, input int c);
        logic [31:0] v;
        v = (c == 2) ? mem_z[a] : mem_m[a];
        if (c != 1 && wr_en && m_phase != 1 && a == wr_addr) v = merge32(v, wr_data, wr_be);
        if (c == 2 && a == 4'd0) v = '0;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = '0;
            mem_z[i] = '0;
        end
        m_phase = 0;
        m_cnt   = 0;
    endtask

    // Effect of one rising edge, using the inputs that were stable across it.
    task automatic model_edge();
        if (!rst_n) return;
        if (m_phase == 1) begin
            mem_m[m_cnt] = '0;
            mem_z[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 16) m_phase = 2;
        end else begin
            if (wr_en) begin
                mem_m[wr_addr] = merge32(mem_m[wr_addr], wr_data, wr_be);
                if (wr_addr != 4'd0) mem_z[wr_addr] = merge32(mem_z[wr_addr], wr_data, wr_be);
            end
            if (clr_req) begin
                m_phase = 1;
                m_cnt   = 0;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; outputs are checked before the next rise.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        wr_en   = 1'b0;
        clr_req = 1'b0;
        wr_be   = 4'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hA5A5_5A5A; wr_be = 4'hF;
        rd0_addr = 4'd5; rd1_addr = 4'd9; clr_req = 1'b0;
        w_wr_en = 1'b0; w_clr_req = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_wr_be = '0;
        w_rd0_addr = 5'd0; w_rd1_addr = 5'd31;
        #12;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (r0[c] !== 32'h0 || r1[c] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd cfg%0d: got %h/%h want 0/0", c, r0[c], r1[c]);
            end
            n_cmp++;
            if (busy[c] !== 1'b0 || done[c] !== 1'b0 || st[c] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_ctl cfg%0d: busy %b done %b st %0d want 0 0 0", c, busy[c], done[c], st[c]);
            end
        end
        n_cmp++;
        if (w_r0 !== 64'h0 || w_r1 !== 64'h0 || w_busy !== 1'b0 || w_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wide: rd %h/%h busy %b done %b want zeros", w_r0, w_r1, w_busy, w_done);
        end
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write_readback();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'hFFFF_FF00 + 32'(i); wr_be = 4'hF;
            cycle();
        end
        set_idle();
        for (int i = 0; i < 16; i++) begin
            rd0_addr = 4'(i);
            rd1_addr = 4'(15 - i);
            #1;
            for (int c = 0; c < 2; c++) begin
                n_cmp++;
                if (r0[c] !== 32'hFFFF_FF00 + 32'(i) || r1[c] !== 32'hFFFF_FF0F - 32'(i)) begin
                    n_fail++;
                    $display("FAIL readback cfg%0d i=%0d: got %h/%h want %h/%h", c, i, r0[c], r1[c],
                             32'hFFFF_FF00 + 32'(i), 32'hFFFF_FF0F - 32'(i));
                end
            end
            n_cmp++;
            if (r0[2] !== exp_rd(rd0_addr, 2) || r1[2] !== exp_rd(rd1_addr, 2)) begin
                n_fail++;
                $display("FAIL readback cfg2 i=%0d: got %h/%h want %h/%h", i, r0[2], r1[2],
                         exp_rd(rd0_addr, 2), exp_rd(rd1_addr, 2));
            end
            cycle();
        end
    endtask

    task automatic test_byte_bypass();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1122_3344; wr_be = 4'hF;
        cycle();
        wr_data = 32'hAABB_CCDD; wr_be = 4'b0101; rd0_addr = 4'd3; rd1_addr = 4'd3;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (r0[c] !== ((c == 1) ? 32'h1122_3344 : 32'h11BB_33DD) ||
                r1[c] !== ((c == 1) ? 32'h1122_3344 : 32'h11BB_33DD)) begin
                n_fail++;
                $display("FAIL bypass_same_cycle cfg%0d: got %h/%h want %h", c, r0[c], r1[c],
                         (c == 1) ? 32'h1122_3344 : 32'h11BB_33DD);
            end
        end
        cycle();
        // Zero byte enables: accepted, nothing changes, bypass shows the old value.
        wr_data = 32'hFFFF_FFFF; wr_be = 4'h0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (r0[c] !== 32'h11BB_33DD || r1[c] !== 32'h11BB_33DD) begin
                n_fail++;
                $display("FAIL byte_merge_after cfg%0d: got %h/%h want 11bb33dd", c, r0[c], r1[c]);
            end
        end
        cycle();
        set_idle();
        #1;
        n_cmp++;
        if (r0[0] !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL be_zero_hold: got %h want 11bb33dd", r0[0]);
        end
        cycle();
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        rd0_addr = 4'd0; rd1_addr = 4'd1;
        #1;
        n_cmp++;
        if (r0[2] !== 32'h0 || r0[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL zero_reg_before: cfg2 %h want 0, cfg0 %h want deadbeef", r0[2], r0[0]);
        end
        cycle();
        wr_addr = 4'd1; wr_data = 32'h0BAD_F00D;
        #1;
        n_cmp++;
        if (r0[2] !== 32'h0 || r1[2] !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL zero_reg_after: rd0 %h want 0, rd1 %h want 0badf00d", r0[2], r1[2]);
        end
        cycle();
        set_idle();
        #1;
        n_cmp++;
        if (r0[2] !== 32'h0 || r1[2] !== 32'h0BAD_F00D || r0[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL zero_reg_settle: cfg2 %h/%h cfg0 %h want 0/0badf00d/deadbeef", r0[2], r1[2], r0[0]);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = $urandom;
            wr_be    = 4'($urandom_range(0, 15));
            clr_req  = ($urandom_range(0, 49) == 0);
            rd0_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd1_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            #1;
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (r0[c] !== exp_rd(rd0_addr, c) || r1[c] !== exp_rd(rd1_addr, c)) begin
                    n_fail++;
                    $display("FAIL rand_rd cfg%0d n=%0d a=%0d/%0d: got %h/%h want %h/%h", c, n,
                             rd0_addr, rd1_addr, r0[c], r1[c], exp_rd(rd0_addr, c), exp_rd(rd1_addr, c));
                end
                n_cmp++;
                if (busy[c] !== (m_phase == 1) || done[c] !== (m_phase == 2)) begin
                    n_fail++;
                    $display("FAIL rand_ctl cfg%0d n=%0d: busy %b done %b want %b %b", c, n,
                             busy[c], done[c], m_phase == 1, m_phase == 2);
                end
            end
            cycle();
        end
        set_idle();
        for (int k = 0; k < 20 && m_phase != 0; k++) cycle();
    endtask

    task automatic test_bulk_clear();
        logic [31:0] old15;
        int busy_cnt, done_cnt, done_k;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = $urandom | 32'h0000_0100; wr_be = 4'hF;
            cycle();
        end
        set_idle();
        old15 = mem_m[15];
        clr_req = 1'b1;
        cycle();
        busy_cnt = 0; done_cnt = 0; done_k = -1;
        for (int k = 0; k < 24; k++) begin
            set_idle();
            if (busy[0]) busy_cnt++;
            if (busy[0] && busy_cnt == 8) begin
                // Write and clr_req mid-clear must both be ignored.
                wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h1234_5678; wr_be = 4'hF;
                clr_req = 1'b1;
                rd0_addr = 4'd15; rd1_addr = 4'd0;
                #1;
                n_cmp++;
                if (r0[0] !== old15 || r1[0] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL mid_clear_rd: e15 %h want %h, e0 %h want 0", r0[0], old15, r1[0]);
                end
            end
            if (done[0]) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                for (int i = 0; i < 8; i++) begin
                    rd0_addr = 4'(i); rd1_addr = 4'(i + 8);
                    #0.25;
                    for (int c = 0; c < 3; c++) begin
                        n_cmp++;
                        if (r0[c] !== 32'h0 || r1[c] !== 32'h0) begin
                            n_fail++;
                            $display("FAIL clear_result cfg%0d e%0d/e%0d: got %h/%h want 0", c, i, i + 8, r0[c], r1[c]);
                        end
                    end
                end
            end
            cycle();
        end
        n_cmp++;
        if (busy_cnt != 16 || done_cnt != 1 || done_k != 16) begin
            n_fail++;
            $display("FAIL clear_timing: busy %0d done %0d at %0d want 16 1 16", busy_cnt, done_cnt, done_k);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bc, done_seen;
        bit fired;
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
        cycle();
        set_idle();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        bc = 0; fired = 1'b0;
        for (int k = 0; k < 30 && !fired; k++) begin
            if (busy[0]) bc++;
            if (bc == 5) begin
                fired = 1'b1;
                rd0_addr = 4'd15; rd1_addr = 4'd15;
                #1;
                n_cmp++;
                if (r0[0] !== 32'hCAFE_F00D) begin
                    n_fail++;
                    $display("FAIL pre_reset_rd: got %h want cafef00d", r0[0]);
                end
                #1 rst_n = 1'b0;
                #1;
                for (int c = 0; c < 3; c++) begin
                    n_cmp++;
                    if (r0[c] !== 32'h0 || busy[c] !== 1'b0 || done[c] !== 1'b0 || st[c] !== 2'd0) begin
                        n_fail++;
                        $display("FAIL async_reset cfg%0d: rd %h busy %b done %b st %0d want 0", c,
                                 r0[c], busy[c], done[c], st[c]);
                    end
                end
            end else begin
                cycle();
            end
        end
        n_cmp++;
        if (!fired) begin
            n_fail++;
            $display("FAIL mid_clear_reach: busy count %0d want 5 within budget", bc);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done[0] || busy[0]) done_seen++;
            cycle();
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL no_done_after_reset: busy/done cycles %0d want 0", done_seen);
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_7777; wr_be = 4'hF;
        cycle();
        set_idle();
        rd0_addr = 4'd7;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (r0[c] !== 32'h0000_7777) begin
                n_fail++;
                $display("FAIL write_after_reset cfg%0d: got %h want 00007777", c, r0[c]);
            end
        end
        cycle();
    endtask

    task automatic test_wide();
        logic [63:0] d0, d31, e31;
        int busy_cnt, done_k;
        d0  = {$urandom, $urandom};
        d31 = {$urandom, $urandom};
        w_wr_en = 1'b1; w_wr_addr = 5'd0; w_wr_data = d0; w_wr_be = 8'hFF;
        cycle();
        w_wr_addr = 5'd31; w_wr_data = d31;
        cycle();
        w_wr_en = 1'b0;
        w_rd0_addr = 5'd0; w_rd1_addr = 5'd31;
        #1;
        n_cmp++;
        if (w_r0 !== d0 || w_r1 !== d31) begin
            n_fail++;
            $display("FAIL wide_readback: got %h/%h want %h/%h", w_r0, w_r1, d0, d31);
        end
        e31 = {32'hFFFF_FFFF, d31[31:0]};
        w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wr_data = '1; w_wr_be = 8'hF0;
        #1;
        n_cmp++;
        if (w_r1 !== e31) begin
            n_fail++;
            $display("FAIL wide_bypass: got %h want %h", w_r1, e31);
        end
        cycle();
        w_wr_en = 1'b0;
        w_clr_req = 1'b1;
        #1;
        n_cmp++;
        if (w_r1 !== e31 || w_r0 !== d0) begin
            n_fail++;
            $display("FAIL wide_byte_merge: got %h/%h want %h/%h", w_r0, w_r1, d0, e31);
        end
        cycle();
        w_clr_req = 1'b0;
        busy_cnt = 0; done_k = -1;
        for (int k = 0; k < 40; k++) begin
            if (w_busy) busy_cnt++;
            if (w_done && done_k < 0) done_k = k;
            cycle();
        end
        n_cmp++;
        if (busy_cnt != 32 || done_k != 32) begin
            n_fail++;
            $display("FAIL wide_clear_timing: busy %0d done at %0d want 32 32", busy_cnt, done_k);
        end
        n_cmp++;
        if (w_r0 !== 64'h0 || w_r1 !== 64'h0) begin
            n_fail++;
            $display("FAIL wide_clear_result: got %h/%h want 0", w_r0, w_r1);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write_readback();
        test_byte_bypass();
        test_zero_reg();
        test_random();
        test_bulk_clear();
        test_reset_mid_clear();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
